// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: state encoding, default
// operand width and the shift-count saturation helper.
package shift_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 12;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Requested counts beyond the operand width saturate to the width.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] n, input int width);
    if (int'(n) > width) begin
      return CNT_W'(width);
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_sequencer_left_shift_1.sv
// Single-bit left shifter: the extra output MSB carries the bit shifted out,
// and a zero is filled in at the LSB.
module left_shift_1
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH:0]   data_o
);

  assign data_o = {data_i, 1'b0};

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle left shifter: accepts an operand and a shift count, shifts one
// bit per clock and reports whether any set bit fell off the MSB.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [3:0]       N,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] R,
  output logic             OVF
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   sh_out;
  logic [CNT_W-1:0] n_eff;

  left_shift_1 #(.WIDTH(WIDTH)) u_shift (
    .data_i (work_q),
    .data_o (sh_out)
  );

  assign n_eff = sat_count(N, WIDTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          work_d  = A;
          ovf_d   = 1'b0;
          cnt_d   = n_eff;
          state_d = (n_eff != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        // The edge doing the final shift also moves us into DONE.
        work_d = sh_out[WIDTH-1:0];
        ovf_d  = ovf_q | sh_out[WIDTH];
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign R    = work_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer at the default 12-bit width.
module tb_shift_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [11:0] A;
  logic [3:0]  N;
  logic        BUSY;
  logic        DONE;
  logic [11:0] R;
  logic        OVF;

  int checks   = 0;
  int failures = 0;

  shift_sequencer #(.WIDTH(12)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .N     (N),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .R     (R),
    .OVF   (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Starts one operation from the current negedge and observes it until the
  // IDLE cycle after DONE (or a 40-cycle budget). done_at counts negedges
  // after the accepting edge; -1 means DONE never appeared.
  task automatic run_op(input logic [11:0] a, input logic [3:0] n,
                        output int done_at, output int busy_cnt, output int done_cnt);
    done_at  = -1;
    busy_cnt = 0;
    done_cnt = 0;
    A     = a;
    N     = n;
    START = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        START = 1'b0;
        A     = ~a;
        N     = ~n;
      end
      if (BUSY) busy_cnt++;
      if (DONE) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (done_at >= 0 && k == done_at + 1) break;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    START = 1'b1;
    A     = 12'hFFF;
    N     = 4'd3;
    repeat (2) @(negedge CLK);
    checks++;
    if ({BUSY, DONE, OVF, R} !== 15'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b ovf=%b r=%h, want all zero", BUSY, DONE, OVF, R);
    end
    RST_N = 1'b1;
    A     = 12'h005;
    N     = 4'd1;
    @(negedge CLK);
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL first_start_accepted: got busy=%b, want 1", BUSY);
    end
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b1 || R !== 12'h00A) begin
      failures++;
      $display("[TB] FAIL first_op_result: got done=%b r=%h, want done=1 r=00a", DONE, R);
    end
    @(negedge CLK);
  endtask

  task automatic test_single_shift();
    int d, b, c;
    run_op(12'hFFF, 4'd1, d, b, c);
    checks++;
    if (d !== 2) begin
      failures++;
      $display("[TB] FAIL fff_n1_latency: got %0d, want 2", d);
    end
    checks++;
    if (R !== 12'hFFE || OVF !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fff_n1_result: got r=%h ovf=%b, want r=ffe ovf=1", R, OVF);
    end
  endtask

  task automatic test_multi_shift();
    int d, b, c;
    run_op(12'hAAA, 4'd4, d, b, c);
    checks++;
    if (b !== 4 || d !== 5) begin
      failures++;
      $display("[TB] FAIL aaa_n4_timing: got busy=%0d done_at=%0d, want busy=4 done_at=5", b, d);
    end
    checks++;
    if (c !== 1) begin
      failures++;
      $display("[TB] FAIL aaa_n4_done_width: got %0d cycles, want 1", c);
    end
    checks++;
    if (R !== 12'hAA0 || OVF !== 1'b1) begin
      failures++;
      $display("[TB] FAIL aaa_n4_result: got r=%h ovf=%b, want r=aa0 ovf=1", R, OVF);
    end
    A = 12'h123;
    N = 4'd7;
    repeat (3) @(negedge CLK);
    checks++;
    if (R !== 12'hAA0 || OVF !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_hold: got r=%h ovf=%b busy=%b done=%b, want r=aa0 ovf=1 busy=0 done=0", R, OVF, BUSY, DONE);
    end
  endtask

  task automatic test_zero_shift();
    int d, b, c;
    run_op(12'h333, 4'd0, d, b, c);
    checks++;
    if (b !== 0 || d !== 1) begin
      failures++;
      $display("[TB] FAIL n0_timing: got busy=%0d done_at=%0d, want busy=0 done_at=1", b, d);
    end
    checks++;
    if (R !== 12'h333 || OVF !== 1'b0) begin
      failures++;
      $display("[TB] FAIL n0_result: got r=%h ovf=%b, want r=333 ovf=0", R, OVF);
    end
  endtask

  task automatic test_saturate();
    int d, b, c;
    run_op(12'h001, 4'd15, d, b, c);
    checks++;
    if (b !== 12 || d !== 13) begin
      failures++;
      $display("[TB] FAIL sat_timing: got busy=%0d done_at=%0d, want busy=12 done_at=13", b, d);
    end
    checks++;
    if (R !== 12'h000 || OVF !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_result: got r=%h ovf=%b, want r=000 ovf=1", R, OVF);
    end
  endtask

  task automatic test_ignore_start();
    int d, c;
    d = -1;
    c = 0;
    A     = 12'h0F0;
    N     = 4'd3;
    START = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        A     = 12'hFFF;
        N     = 4'd9;
        START = 1'b1;
      end
      if (k == 2) START = 1'b0;
      if (DONE) begin
        c++;
        if (d < 0) d = k;
      end
      if (d >= 0 && k == d + 3) break;
    end
    checks++;
    if (d !== 4 || c !== 1) begin
      failures++;
      $display("[TB] FAIL ignore_timing: got done_at=%0d dones=%0d, want done_at=4 dones=1", d, c);
    end
    checks++;
    if (R !== 12'h780 || OVF !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_result: got r=%h ovf=%b, want r=780 ovf=0", R, OVF);
    end
  endtask

  task automatic test_abort();
    int d, b, c, dones;
    A     = 12'h0FF;
    N     = 4'd5;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    checks++;
    if ({BUSY, DONE, OVF, R} !== 15'h0) begin
      failures++;
      $display("[TB] FAIL abort_state: got busy=%b done=%b ovf=%b r=%h, want all zero", BUSY, DONE, OVF, R);
    end
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: got %0d done cycles, want 0", dones);
    end
    run_op(12'h003, 4'd2, d, b, c);
    checks++;
    if (d !== 3 || R !== 12'h00C || OVF !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_abort: got done_at=%0d r=%h ovf=%b, want done_at=3 r=00c ovf=0", d, R, OVF);
    end
  endtask

  task automatic test_back_to_back();
    int d, b, c;
    run_op(12'h80F, 4'd2, d, b, c);
    checks++;
    if (d !== 3 || R !== 12'h03C || OVF !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_first: got done_at=%0d r=%h ovf=%b, want done_at=3 r=03c ovf=1", d, R, OVF);
    end
    run_op(12'h021, 4'd3, d, b, c);
    checks++;
    if (d !== 4 || b !== 3 || R !== 12'h108 || OVF !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_second: got done_at=%0d busy=%0d r=%h ovf=%b, want done_at=4 busy=3 r=108 ovf=0", d, b, R, OVF);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    A     = '0;
    N     = '0;
    test_reset();
    test_single_shift();
    test_multi_shift();
    test_zero_shift();
    test_saturate();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
